// File: rtl/alu_pin_driver.sv
// ---------------------------------------------------------------------------
// alu_pin_driver
//
// Host-side driver for the ALU user-project pin interface. It accepts an
// operand pair on a valid/ready request channel, drives the pair onto
// ui_in/uio_in with ena high, and waits LATENCY clock edges. It then samples
// uo_out and returns it on a valid/ready response channel. While the operands
// are being driven it also watches uio_oe. The ALU must never enable its
// bidirectional outputs during this time, and any such contention is reported
// with the response.
//
// Parameters
//   LATENCY : clk edges from driving the operands to sampling uo_out (1..15)
//   CNT_W   : width of the completed-transaction counter
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_opa/req_opb       : operands, routed to ui_in/uio_in
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data/rsp_err      : captured uo_out, uio_oe contention flag
//   ui_in/uio_in/ena      : pins driven into the ALU
//   uo_out/uio_oe         : pins returned by the ALU
//   txn_count             : number of completed responses (wraps)
// ---------------------------------------------------------------------------
module alu_pin_driver #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_opa,
  input  logic [7:0]       req_opb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic [7:0]       ui_in,
  output logic [7:0]       uio_in,
  output logic             ena,
  input  logic [7:0]       uo_out,
  input  logic [7:0]       uio_oe,
  output logic [CNT_W-1:0] txn_count
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("alu_pin_driver: LATENCY must be in 1..15");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Final DRIVE count. The cycle counter starts at 0 on the edge after
  // acceptance, so the response lands exactly LATENCY edges after the accept.
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  logic [1:0]       state_reg;
  logic [3:0]       cnt_reg;
  logic             err_flag_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic [7:0]       rsp_data_reg;
  logic             rsp_err_reg;
  logic [7:0]       ui_in_reg;
  logic [7:0]       uio_in_reg;
  logic             ena_reg;
  logic [CNT_W-1:0] txn_count_reg;

  // Contention seen on the current edge (only meaningful in DRIVE).
  logic oe_seen;
  assign oe_seen = |uio_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      err_flag_reg  <= 1'b0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      ui_in_reg     <= '0;
      uio_in_reg    <= '0;
      ena_reg       <= 1'b0;
      txn_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            ui_in_reg     <= req_opa;
            uio_in_reg    <= req_opb;
            ena_reg       <= 1'b1;
            cnt_reg       <= '0;
            err_flag_reg  <= 1'b0;
            req_ready_reg <= 1'b0;
            state_reg     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          cnt_reg      <= cnt_reg + 4'd1;
          err_flag_reg <= err_flag_reg | oe_seen;
          if (cnt_reg == LAST_CNT) begin
            rsp_data_reg  <= uo_out;
            // Include this edge's uio_oe; the flag register has not absorbed it yet.
            rsp_err_reg   <= err_flag_reg | oe_seen;
            rsp_valid_reg <= 1'b1;
            ena_reg       <= 1'b0;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // req_ready rises only after the response handshake, so accepts are
          // spaced at least LATENCY+2 edges apart.
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            txn_count_reg <= txn_count_reg + 1'b1;
            req_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
          ena_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign ui_in     = ui_in_reg;
  assign uio_in    = uio_in_reg;
  assign ena       = ena_reg;
  assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_alu_pin_driver.sv
module tb_alu_pin_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance: LATENCY=2, CNT_W=16
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ena;
  logic [7:0]  req_opa, req_opb, rsp_data, ui_in, uio_in, uo_out, uio_oe;
  logic [15:0] txn_count;
  logic [7:0]  oe_drive;

  // Second instance: LATENCY=1, CNT_W=2 (latency and wrap checks)
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b, ena_b;
  logic [7:0]  req_opa_b, req_opb_b, rsp_data_b, ui_in_b, uio_in_b, uo_out_b, uio_oe_b;
  logic [1:0]  txn_count_b;

  // ALU models: result is opa+opb.
  assign uo_out   = ui_in + uio_in;
  assign uio_oe   = oe_drive;
  assign uo_out_b = ui_in_b + uio_in_b;
  assign uio_oe_b = 8'h00;

  alu_pin_driver #(.LATENCY(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ui_in(ui_in), .uio_in(uio_in), .ena(ena),
    .uo_out(uo_out), .uio_oe(uio_oe), .txn_count(txn_count)
  );

  alu_pin_driver #(.LATENCY(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_opa(req_opa_b), .req_opb(req_opb_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
    .ui_in(ui_in_b), .uio_in(uio_in_b), .ena(ena_b),
    .uo_out(uo_out_b), .uio_oe(uio_oe_b), .txn_count(txn_count_b)
  );

  typedef struct {
    logic [7:0] opa;
    logic [7:0] opb;
    bit         inject;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request on the main instance and wait for its response
  // (rsp_ready is left to the caller).
  task automatic run_to_rsp(input vec_t v);
    int ena_cnt;
    int lat;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 1);
    req_opa   = v.opa;
    req_opb   = v.opb;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_opa   = ~v.opa;   // operands may change after acceptance
    req_opb   = 8'h5A;
    check("ui_in_driven", 32'(ui_in), 32'(v.opa));
    check("uio_in_driven", 32'(uio_in), 32'(v.opb));
    check("req_ready_busy", 32'(req_ready), 0);
    ena_cnt = 0;
    lat     = 0;
    while (!rsp_valid && lat < 20) begin
      if (ena) ena_cnt++;
      oe_drive = (v.inject && lat == 0) ? 8'h01 : 8'h00;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    oe_drive = 8'h00;
    check("rsp_latency", lat, 2);
    check("ena_cycles", ena_cnt, 2);
    check("ena_low_in_resp", 32'(ena), 0);
    check("rsp_data", 32'(rsp_data), 32'(v.exp_data));
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("ui_in_held", 32'(ui_in), 32'(v.opa));
    $display("txn opa=%02h opb=%02h inject=%0d -> data=%02h err=%0d lat=%0d",
             v.opa, v.opb, v.inject, rsp_data, rsp_err, lat);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    check("rsp_valid_cleared", 32'(rsp_valid), 0);
    check("txn_count", 32'(txn_count), exp_cnt);
    check("req_ready_after_rsp", 32'(req_ready), 1);
  endtask

  initial begin
    int acc_cyc[4];
    int n_acc;
    int n_rsp;
    int expb;
    vec_t bp;

    vecs[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_opa = '0; req_opb = '0; rsp_ready = 1'b0; oe_drive = '0;
    req_valid_b = 1'b0; req_opa_b = '0; req_opb_b = '0; rsp_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_ui_in", 32'(ui_in), 0);
    check("rst_uio_in", 32'(uio_in), 0);
    check("rst_ena", 32'(ena), 0);
    check("rst_txn_count", 32'(txn_count), 0);
    check("rst_txn_count_b", 32'(txn_count_b), 0);
    rst_n = 1'b1;

    // Single transactions: basic, wraparound sum, contention, clean follow-up.
    for (int i = 0; i < 4; i++) begin
      run_to_rsp(vecs[i]);
      finish_rsp();
    end

    // Backpressure: response held for 5 cycles while a new request is offered.
    bp = '{8'h21, 8'h43, 1'b0, 8'h64, 1'b0};
    run_to_rsp(bp);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_opa   = 8'h77;
      req_opb   = 8'h77;
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_data", 32'(rsp_data), 32'h64);
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_ena", 32'(ena), 0);
    end
    req_valid = 1'b0;
    finish_rsp();
    @(posedge clk);
    @(negedge clk);
    check("bp_no_stray_accept", 32'(ena), 0);
    check("bp_ui_in_held", 32'(ui_in), 32'h21);

    // Back-to-back with req_valid held high and rsp_ready=1.
    n_acc = 0;
    n_rsp = 0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 60 && n_rsp < 4; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("b2b_data", 32'(rsp_data), 32'(vecs[4 + n_rsp].exp_data));
        check("b2b_err", 32'(rsp_err), 0);
        $display("txn b2b #%0d data=%02h", n_rsp, rsp_data);
        n_rsp++;
      end
      if (req_ready) begin
        if (n_acc < 4) begin
          req_opa   = vecs[4 + n_acc].opa;
          req_opb   = vecs[4 + n_acc].opb;
          req_valid = 1'b1;
          acc_cyc[n_acc] = cyc;
          n_acc++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_responses", n_rsp, 4);
    for (int i = 1; i < 4; i++)
      check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt += 4;
    check("b2b_txn_count", 32'(txn_count), exp_cnt);
    @(posedge clk);
    @(negedge clk);
    check("b2b_no_extra", 32'(ena), 0);

    // Reset in the middle of DRIVE.
    @(negedge clk);
    req_opa = 8'h11; req_opb = 8'h22; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_ena_before_rst", 32'(ena), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ena", 32'(ena), 0);
    check("mid_rst_ui_in", 32'(ui_in), 0);
    check("mid_rst_uio_in", 32'(uio_in), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_txn_count", 32'(txn_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_idle_rsp", 32'(rsp_valid), 0);
    end
    check("post_rst_req_ready", 32'(req_ready), 1);
    run_to_rsp(vecs[0]);
    finish_rsp();

    // LATENCY=1 instance: latency and 2-bit counter wrap (1,2,3,0,1).
    expb = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("l1_req_ready", 32'(req_ready_b), 1);
      req_opa_b = 8'(3 * i + 1);
      req_opb_b = 8'h10;
      req_valid_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_b = 1'b0;
      check("l1_not_early", 32'(rsp_valid_b), 0);
      @(posedge clk);
      @(negedge clk);
      check("l1_rsp_valid", 32'(rsp_valid_b), 1);
      check("l1_rsp_data", 32'(rsp_data_b), 32'(8'(3 * i + 1) + 8'h10));
      rsp_ready_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready_b = 1'b0;
      expb = (expb + 1) % 4;
      check("l1_txn_count_wrap", 32'(txn_count_b), expb);
      $display("txn lat1 #%0d data=%02h txn_count=%0d", i, rsp_data_b, txn_count_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pin_driver.md
Name: alu_pin_driver

Overview:
- Host-side driver for the ALU user-project pin interface: the opposite end from the pins the ALU consumes.
- Takes operand pairs over a valid/ready request channel and drives them onto ui_in/uio_in with ena high.
- Waits a fixed pipeline latency, then samples uo_out and returns it on a valid/ready response channel.
- Used as the on-chip/FPGA stimulus engine and as a reusable bench component; it also checks that the ALU never enables its bidirectional outputs while being driven.

Parameters:
LATENCY, 2, number of clk edges from driving operands to sampling uo_out; legal range 1..15; 0 must cause an elaboration error
CNT_W, 16, width of the completed-transaction counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request operands valid
req_ready  output  1  driver can accept a request
req_opa  input  8  operand A, routed to ui_in
req_opb  input  8  operand B, routed to uio_in
rsp_valid  output  1  response holds a result
rsp_ready  input  1  consumer accepts the response
rsp_data  output  8  captured uo_out
rsp_err  output  1  uio_oe contention seen during this transaction
ui_in  output  8  to ALU dedicated inputs
uio_in  output  8  to ALU bidirectional input path
ena  output  1  ALU enable
uo_out  input  8  from ALU dedicated outputs
uio_oe  input  8  from ALU bidirectional output enables
txn_count  output  CNT_W  number of completed responses

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- States: IDLE, DRIVE, RESP. All state is cleared asynchronously when rst_n is low.
- Reset values:
  - state IDLE; req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - ui_in=0, uio_in=0, ena=0, txn_count=0.
- Outputs are registered. req_ready is 1 only in IDLE.
- IDLE: on an edge where req_valid&&req_ready:
  - register ui_in<=req_opa, uio_in<=req_opb, ena<=1;
  - clear cnt and the error flag;
  - go to DRIVE.
- DRIVE:
  - cnt increments each edge.
  - On every edge in DRIVE, the error flag ORs in (|uio_oe).
  - At the edge where cnt==LATENCY-1:
    - rsp_data<=uo_out; rsp_err<=flag|(|uio_oe);
    - rsp_valid<=1; ena<=0; go to RESP.
  - Net timing: request accepted at edge E0 gives rsp_valid high after edge E0+LATENCY, and uo_out is sampled at that edge.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that edge: rsp_valid<=0, txn_count<=txn_count+1, go to IDLE.
  - txn_count wraps from all-ones to 0.
- Pin holding:
  - ui_in/uio_in keep their last driven values after DRIVE; they change only on request accept or reset.
  - ena is high exactly during DRIVE.
- Throughput: one transaction per LATENCY+2 edges minimum. There is no accept in the same edge as the response handshake, because req_ready rises the cycle after.
- Inputs are ignored outside their legal states:
  - req_valid in DRIVE/RESP;
  - rsp_ready in IDLE/DRIVE;
  - uio_oe outside DRIVE.
- Reset mid-transaction: the pending response is discarded, ena drops immediately (async), and nothing is counted.
- The request operands are not required to stay stable after acceptance.

Test Plan:
- Reset, LATENCY=2, ALU model returns opa+opb. Send opa=0x12, opb=0x34, rsp_ready=1 -> ena high for exactly 2 cycles, rsp_valid after E0+2, rsp_data=0x46, rsp_err=0, txn_count=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data stays stable, req_ready=0, a second req_valid is not accepted; release -> txn_count increments once.
- Contention: ALU model drives uio_oe=0x01 for one cycle mid-DRIVE -> rsp_err=1 on that response only; the next clean transaction gives rsp_err=0.
- Back-to-back: 4 requests with req_valid held high, rsp_ready=1 -> accepts spaced LATENCY+2 edges apart, results in order, txn_count=4.
- Reset mid-DRIVE: drop rst_n asynchronously -> ena/ui_in/uio_in/rsp_valid go 0 immediately, txn_count=0, req_ready=1 after release.
- Wrap: CNT_W=2, 5 transactions -> txn_count sequence 1,2,3,0,1; LATENCY=1 variant gives rsp_valid after E0+1.
